// File: rtl/mux_pkg.sv
// Shared types for the arbitrating mux family.
package mux_pkg;

  typedef enum logic [1:0] {MODE_SEL, MODE_FIXED, MODE_RR, MODE_RSVD} mux_mode_e;

endpackage

// File: rtl/rr_pick.sv
// Circular first-set search: returns the first asserted req at or after start,
// wrapping modulo N_CH.
module rr_pick #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] start,
  output logic             gnt_vld,
  output logic [SEL_W-1:0] gnt_idx
);

  localparam int unsigned SUM_W = SEL_W + 1;

  logic [SUM_W-1:0] base;
  logic [SUM_W-1:0] cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    base    = ({1'b0, start} < SUM_W'(N_CH)) ? {1'b0, start} : '0;
    // Walk offsets from farthest to nearest so the nearest request is the last write.
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = base + SUM_W'(k);
      if (cand >= SUM_W'(N_CH)) begin
        cand = cand - SUM_W'(N_CH);
      end
      if (req[cand[SEL_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel arbitrating mux with select / fixed-priority / round-robin grant
// and a 1-deep registered valid/ready output stage.
module mux_rr_arb
  import mux_pkg::*;
#(
  parameter  int unsigned N_CH  = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);

  mux_mode_e        mode_e;
  logic             sel_vld;
  logic             pick_vld;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] pick_start;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic [SEL_W-1:0] rr_ptr;
  logic             load_en;
  logic             xfer;

  assign mode_e = mux_mode_e'(mode);

  // Out-of-range sel matches no channel, so it yields no grant.
  always_comb begin
    sel_vld = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_vld = in_valid[i];
      end
    end
  end

  // FIXED and reserved modes search from channel 0; RR searches from rr_ptr.
  assign pick_start = (mode_e == MODE_RR) ? rr_ptr : '0;

  rr_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_pick (
    .req     (in_valid),
    .start   (pick_start),
    .gnt_vld (pick_vld),
    .gnt_idx (pick_idx)
  );

  always_comb begin
    grant_vld = pick_vld;
    grant_idx = pick_idx;
    if (mode_e == MODE_SEL) begin
      grant_vld = sel_vld;
      grant_idx = sel;
    end
  end

  assign load_en = !out_valid || out_ready;
  assign xfer    = !rst && load_en && grant_vld;

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        in_ready[i] = xfer;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage: load on transfer, drain when consumed, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer advances past the winner only on RR transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer && (mode_e == MODE_RR)) begin
      rr_ptr <= (grant_idx == SEL_W'(N_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_rr_arb.sv
// Bench for mux_rr_arb: directed scenarios plus randomized traffic on a 4-channel
// and a 5-channel instance, checked against a behavioural grant/scoreboard model.
module tb_mux_rr_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  mode4, mode5;
  logic [1:0]  sel4;
  logic [2:0]  sel5;
  logic [3:0]  iv4, ir4;
  logic [4:0]  iv5, ir5;
  logic [31:0] id4;
  logic [79:0] id5;
  logic        ov4, ov5, ordy4, ordy5;
  logic [7:0]  od4;
  logic [15:0] od5;
  logic [1:0]  oc4;
  logic [2:0]  oc5;

  mux_rr_arb #(.N_CH(4), .WIDTH(8)) dut4 (
    .clk(clk), .rst(rst), .mode(mode4), .sel(sel4), .in_valid(iv4), .in_data(id4),
    .in_ready(ir4), .out_valid(ov4), .out_data(od4), .out_ch(oc4), .out_ready(ordy4)
  );

  mux_rr_arb #(.N_CH(5), .WIDTH(16)) dut5 (
    .clk(clk), .rst(rst), .mode(mode5), .sel(sel5), .in_valid(iv5), .in_data(id5),
    .in_ready(ir5), .out_valid(ov5), .out_data(od5), .out_ch(oc5), .out_ready(ordy5)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference grant: -1 for none; SEL picks sel, otherwise a modular scan from start.
  function automatic int ref_grant(input int n, input int md, input int s,
                                   input logic [7:0] v, input int ptr);
    int start;
    if (md == 0) return (s < n && v[s]) ? s : -1;
    start = (md == 2) ? ptr : 0;
    for (int k = 0; k < n; k++) begin
      if (v[(start + k) % n]) return (start + k) % n;
    end
    return -1;
  endfunction

  // Model of the 4-channel instance's output stage and RR pointer.
  logic       m_v;
  logic [7:0] m_d;
  int         m_c, m_ptr;

  task automatic cyc4();
    int g;
    logic [3:0] er;
    #1;
    g  = ref_grant(4, int'(mode4), int'(sel4), {4'b0, iv4}, m_ptr);
    er = '0;
    if (!rst && (!m_v || ordy4) && g >= 0) er[g] = 1'b1;
    chk("in_ready4", 32'(ir4), 32'(er));
    chk("out_valid4", 32'(ov4), 32'(m_v));
    chk("out_data4", 32'(od4), 32'(m_d));
    chk("out_ch4", 32'(oc4), 32'(m_c));
    @(posedge clk);
    if (rst) begin
      m_v = 0; m_d = '0; m_c = 0; m_ptr = 0;
    end else if (er != 0) begin
      m_v = 1; m_d = id4[g*8 +: 8]; m_c = g;
      if (mode4 == 2'd2) m_ptr = (g + 1) % 4;
    end else if (ordy4) begin
      m_v = 0;
    end
    @(negedge clk);
  endtask

  typedef struct { int ch; logic [15:0] d; } item_t;
  item_t q[$];
  item_t it;
  int    ptr5, g5;
  int    waitc[5];
  logic [4:0] er5;
  int    rr_exp[3] = '{3, 0, 3};

  initial begin
    rst = 1'b1;
    mode4 = 2'd0; sel4 = '0; iv4 = '0; ordy4 = 1'b1;
    mode5 = 2'd2; sel5 = '0; iv5 = '0; ordy5 = 1'b1; id5 = '0;
    for (int i = 0; i < 4; i++) id4[i*8 +: 8] = 8'hA0 + 8'(i);
    m_v = 0; m_d = '0; m_c = 0; m_ptr = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // SEL mode
    mode4 = 2'd0; sel4 = 2'd2; iv4 = 4'b1111; ordy4 = 1'b1;
    #1 chk("sel_in_ready", 32'(ir4), 32'h4);
    cyc4();
    chk("sel_data", 32'(od4), 32'hA2);
    chk("sel_ch", 32'(oc4), 32'd2);
    iv4 = 4'b1011;
    cyc4();
    chk("sel_nogrant_valid", 32'(ov4), 32'd0);

    // FIXED mode: ch1 wins every cycle with no bubbles
    mode4 = 2'd1; iv4 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cyc4();
      chk("fixed_valid", 32'(ov4), 32'd1);
      chk("fixed_ch", 32'(oc4), 32'd1);
    end

    // RR mode sweep then sparse valids
    mode4 = 2'd2; iv4 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc4();
      chk("rr_seq_ch", 32'(oc4), 32'(i % 4));
    end
    iv4 = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      cyc4();
      chk("rr_sparse_ch", 32'(oc4), 32'(rr_exp[i]));
    end

    // Stall holds the word and blocks all inputs
    iv4 = 4'b1111; ordy4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc4();
      chk("stall_data", 32'(od4), 32'hA3);
      chk("stall_ch", 32'(oc4), 32'd3);
    end
    ordy4 = 1'b1;
    #1 chk("stall_release_ready", 32'(ir4), 32'h1);
    cyc4();

    // Reset during a stall
    ordy4 = 1'b0;
    cyc4();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(ov4), 32'd0);
    chk("rst_ch", 32'(oc4), 32'd0);
    chk("rst_in_ready", 32'(ir4), 32'd0);
    m_v = 0; m_d = '0; m_c = 0; m_ptr = 0;
    cyc4();
    rst = 1'b0; mode4 = 2'd2; iv4 = 4'b1111; ordy4 = 1'b1;
    cyc4();
    chk("rst_rr_ptr_ch", 32'(oc4), 32'd0);

    // Randomized traffic on the 4-channel instance, all modes
    for (int n = 0; n < 300; n++) begin
      mode4 = 2'($urandom_range(0, 3));
      sel4  = 2'($urandom_range(0, 3));
      iv4   = 4'($urandom);
      id4   = $urandom;
      ordy4 = ($urandom_range(0, 3) != 0);
      cyc4();
    end
    iv4 = '0; ordy4 = 1'b1;

    // Randomized RR scoreboard on the 5-channel instance
    ptr5 = 0;
    for (int i = 0; i < 5; i++) waitc[i] = 0;
    for (int n = 0; n < 600; n++) begin
      ordy5 = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 5; i++) begin
        if (!iv5[i] && $urandom_range(0, 2) == 0) begin
          iv5[i] = 1'b1;
          id5[i*16 +: 16] = 16'($urandom);
          waitc[i] = 0;
        end
      end
      #1;
      g5  = ref_grant(5, 2, 0, {3'b0, iv5}, ptr5);
      er5 = '0;
      if ((q.size() == 0 || ordy5) && g5 >= 0) er5[g5] = 1'b1;
      chk("in_ready5", 32'(ir5), 32'(er5));
      chk("out_valid5", 32'(ov5), 32'(q.size() != 0));
      if (q.size() != 0 && ordy5) begin
        it = q.pop_front();
        chk("sb_ch5", 32'(oc5), 32'(it.ch));
        chk("sb_data5", 32'(od5), 32'(it.d));
      end
      if (er5 != 0) begin
        it.ch = g5; it.d = id5[g5*16 +: 16];
        q.push_back(it);
        chk("rr_wait5", 32'(waitc[g5] > 4), 32'd0);
        for (int j = 0; j < 5; j++) if (j != g5 && iv5[j]) waitc[j]++;
        ptr5 = (g5 + 1) % 5;
      end
      @(posedge clk);
      @(negedge clk);
      if (er5 != 0) iv5[g5] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
